// File: rtl/top_if.sv
`default_nettype none
// ============================================================================
//  Module   : top_if
//  Brief    : MIPS instruction-fetch stage: PC, instruction memory, IF/ID regs.
//  Revision : 1.0
// ============================================================================
module top_if #(
    parameter int LENGTH_INSTRUCTION = 32,
    parameter int CANT_BITS_ADDR     = 11,
    parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
    parameter logic [LENGTH_INSTRUCTION-1:0] NOP_INSTRUCTION  = 32'h0000_0000
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_enable_pipeline,
    input  logic                          i_start,
    input  logic                          i_bit_burbuja_hazard,
    input  logic                          i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
    input  logic                          i_mem_write_enable,
    input  logic [CANT_BITS_ADDR-1:0]     i_mem_write_addr,
    input  logic [LENGTH_INSTRUCTION-1:0] i_mem_write_data,
    output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
    output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
    output logic [CANT_BITS_ADDR-1:0]     o_pc,
    output logic                          o_halt_detected,
    output logic                          o_running
);

    localparam int c_DEPTH = 2 ** CANT_BITS_ADDR;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                          r_state_q, w_state_d;
    logic [CANT_BITS_ADDR-1:0]       r_pc_q, w_pc_d;
    logic [LENGTH_INSTRUCTION-1:0]   r_instr_q, w_instr_d;
    logic [CANT_BITS_ADDR-1:0]       r_adder_q, w_adder_d;
    logic                            r_halt_q, w_halt_d;
    logic                            r_running_q, w_running_d;

    logic [LENGTH_INSTRUCTION-1:0]   r_mem [c_DEPTH];
    logic [LENGTH_INSTRUCTION-1:0]   w_fetch;
    logic [CANT_BITS_ADDR-1:0]       w_pc_plus1;

    assign w_fetch    = r_mem[r_pc_q];
    assign w_pc_plus1 = r_pc_q + {{(CANT_BITS_ADDR-1){1'b0}}, 1'b1};

    // Program storage has no reset so a loaded program survives a soft reset.
    always_ff @(posedge i_clock) begin
        if (r_state_q == S_LOAD && i_mem_write_enable) begin
            r_mem[i_mem_write_addr] <= i_mem_write_data;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_pc_d      = r_pc_q;
        w_instr_d   = r_instr_q;
        w_adder_d   = r_adder_q;
        w_halt_d    = r_halt_q;
        w_running_d = r_running_q;
        case (r_state_q)
            S_LOAD: begin
                if (i_start) begin
                    w_state_d   = S_RUN;
                    w_pc_d      = '0;
                    w_running_d = 1'b1;
                end
            end
            S_RUN: begin
                // Stall outranks branch: a redirect seen during a bubble is dropped.
                if (i_enable_pipeline && !i_bit_burbuja_hazard) begin
                    if (i_branch_control) begin
                        w_pc_d    = i_branch_dir;
                        w_instr_d = NOP_INSTRUCTION;
                        w_adder_d = '0;
                    end else begin
                        w_instr_d = w_fetch;
                        w_adder_d = w_pc_plus1;
                        if (w_fetch == HALT_INSTRUCTION) begin
                            w_state_d   = S_HALT;
                            w_halt_d    = 1'b1;
                            w_running_d = 1'b0;
                        end else begin
                            w_pc_d = w_pc_plus1;
                        end
                    end
                end
            end
            S_HALT: begin
                w_state_d = S_HALT;
            end
            default: begin
                w_state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            r_state_q   <= S_LOAD;
            r_pc_q      <= '0;
            r_instr_q   <= NOP_INSTRUCTION;
            r_adder_q   <= '0;
            r_halt_q    <= 1'b0;
            r_running_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pc_q      <= w_pc_d;
            r_instr_q   <= w_instr_d;
            r_adder_q   <= w_adder_d;
            r_halt_q    <= w_halt_d;
            r_running_q <= w_running_d;
        end
    end

    assign o_instruction   = r_instr_q;
    assign o_out_adder_pc  = r_adder_q;
    assign o_pc            = r_pc_q;
    assign o_halt_detected = r_halt_q;
    assign o_running       = r_running_q;

endmodule
`default_nettype wire

// File: tb/tb_top_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_top_if
//  Brief    : Vector-table bench for top_if with an expected-result queue.
//  Revision : 1.0
// ============================================================================
module tb_top_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, start, stall, br, we;
    logic [10:0] dir, waddr;
    logic [31:0] wdata;
    logic [31:0] o_instr;
    logic [10:0] o_adder, o_pc;
    logic        o_halt, o_run;

    always #5 clk = ~clk;

    top_if dut (
        .i_clock              (clk),
        .i_soft_reset         (rst),
        .i_enable_pipeline    (en),
        .i_start              (start),
        .i_bit_burbuja_hazard (stall),
        .i_branch_control     (br),
        .i_branch_dir         (dir),
        .i_mem_write_enable   (we),
        .i_mem_write_addr     (waddr),
        .i_mem_write_data     (wdata),
        .o_instruction        (o_instr),
        .o_out_adder_pc       (o_adder),
        .o_pc                 (o_pc),
        .o_halt_detected      (o_halt),
        .o_running            (o_run)
    );

    typedef struct {
        logic        rst, start, en, stall, br, we;
        logic [10:0] dir, wa;
        logic [31:0] wd;
        logic [31:0] e_instr;
        logic [10:0] e_adder, e_pc;
        logic        e_halt, e_run;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] instr;
        logic [10:0] adder, pc;
        logic        halt, run;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    function automatic vec_t mk(logic r, logic s, logic e, logic st, logic b, logic [10:0] d,
                                logic w, logic [10:0] a, logic [31:0] wd,
                                logic [31:0] ei, logic [10:0] ea, logic [10:0] ep,
                                logic eh, logic er);
        vec_t v;
        v.rst = r; v.start = s; v.en = e; v.stall = st; v.br = b; v.dir = d;
        v.we = w; v.wa = a; v.wd = wd;
        v.e_instr = ei; v.e_adder = ea; v.e_pc = ep; v.e_halt = eh; v.e_run = er;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t x;
        exp_t got;
        rst = v.rst; start = v.start; en = v.en; stall = v.stall; br = v.br; dir = v.dir;
        we = v.we; waddr = v.wa; wdata = v.wd;
        x.id = step_id; x.instr = v.e_instr; x.adder = v.e_adder; x.pc = v.e_pc;
        x.halt = v.e_halt; x.run = v.e_run;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL step%0d: scoreboard empty", step_id);
        end else begin
            got = sb_q.pop_front();
            if (o_instr !== got.instr || o_adder !== got.adder || o_pc !== got.pc ||
                o_halt !== got.halt || o_run !== got.run) begin
                bad++;
                $display("FAIL step%0d: got instr=%h adder=%0d pc=%0d halt=%b run=%b, want instr=%h adder=%0d pc=%0d halt=%b run=%b",
                         got.id, o_instr, o_adder, o_pc, o_halt, o_run,
                         got.instr, got.adder, got.pc, got.halt, got.run);
            end
        end
        step_id++;
    endtask

    // Shorthand: one RUN cycle with no writes.
    function automatic vec_t rc(logic e, logic st, logic b, logic [10:0] d,
                                logic [31:0] ei, logic [10:0] ea, logic [10:0] ep);
        return mk(0, 0, e, st, b, d, 0, 11'd0, 32'd0, ei, ea, ep, 0, 1);
    endfunction

    initial begin
        rst = 1; start = 0; en = 0; stall = 0; br = 0; dir = '0; we = 0; waddr = '0; wdata = '0;

        // Reset, load 1,2,3,HALT, start and run into the halt word.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 1, 11'd0, 32'd1, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 1, 11'd1, 32'd2, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 1, 11'd2, 32'd3, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 1, 11'd3, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));
        apply(rc(1, 0, 0, 0, 32'd1, 11'd1, 11'd1));
        apply(rc(1, 0, 0, 0, 32'd2, 11'd2, 11'd2));
        apply(rc(1, 0, 0, 0, 32'd3, 11'd3, 11'd3));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 11'd4, 11'd3, 1, 0));
        // HALT ignores branches and further enables.
        apply(mk(0, 0, 1, 0, 1, 11'd9, 0, 0, 0, 32'hFFFF_FFFF, 11'd4, 11'd3, 1, 0));
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 11'd4, 11'd3, 1, 0));

        // Reset out of HALT and reload everything except mem[0..2].
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        for (int i = 3; i <= 30; i++)
            apply(mk(0, 0, 0, 0, 0, 0, 1, 11'(i), 32'(i + 1), 32'h0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 11'd2047, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));

        tbl.push_back(rc(1, 0, 0, 0,       32'd1,  11'd1,  11'd1));
        tbl.push_back(rc(1, 0, 1, 11'd5,   32'd0,  11'd0,  11'd5));
        tbl.push_back(rc(1, 0, 1, 11'd20,  32'd0,  11'd0,  11'd20));
        tbl.push_back(rc(1, 0, 0, 0,       32'd21, 11'd21, 11'd21));
        tbl.push_back(rc(1, 0, 1, 11'd7,   32'd0,  11'd0,  11'd7));
        tbl.push_back(rc(1, 1, 1, 11'd30,  32'd0,  11'd0,  11'd7));
        tbl.push_back(rc(1, 1, 1, 11'd30,  32'd0,  11'd0,  11'd7));
        tbl.push_back(rc(1, 0, 0, 0,       32'd8,  11'd8,  11'd8));
        // Enable 1,0,0,1 with write strobes that RUN must ignore.
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,      1, 11'd9, 32'hBAD, 32'd9,  11'd9,  11'd9,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 11'd30, 1, 11'd9, 32'hBAD, 32'd9,  11'd9,  11'd9,  0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,      1, 11'd9, 32'hBAD, 32'd9,  11'd9,  11'd9,  0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,      1, 11'd9, 32'hBAD, 32'd10, 11'd10, 11'd10, 0, 1));
        // Top address wraps to 0.
        tbl.push_back(rc(1, 0, 1, 11'd2047, 32'd0,         11'd0, 11'd2047));
        tbl.push_back(rc(1, 0, 0, 0,        32'hDEAD_BEEF, 11'd0, 11'd0));
        tbl.push_back(rc(1, 0, 0, 0,        32'd1,         11'd1, 11'd1));
        tbl.push_back(rc(1, 0, 1, 11'd9,    32'd0,         11'd0, 11'd9));
        foreach (tbl[i]) apply(tbl[i]);

        // Reset mid-RUN at pc=9, idle in LOAD, restart on the retained program.
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 1, 11'd5, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));
        apply(rc(1, 0, 0, 0,     32'd1,  11'd1,  11'd1));
        apply(rc(1, 0, 0, 0,     32'd2,  11'd2,  11'd2));
        apply(rc(1, 0, 1, 11'd9, 32'd0,  11'd0,  11'd9));
        apply(rc(1, 0, 0, 0,     32'd10, 11'd10, 11'd10));

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
